// File: rtl/tdm_demux8.sv
// tdm_demux8 -- time-division 1-to-8 demultiplexer (receive side).
// Rebuilds 8-bit frames from a serial bit stream with a slot-0 frame marker
// and presents each frame on a valid/ready output register.
// Optional macro TDM_DEMUX8_STRICT_SYNC_EN: a bit arriving at slot 0 in COLLECT
// without frame_start raises sync_err and sends the block back to HUNT.
// Handshake: out_data/out_valid are held stable while out_valid=1; a frame is
// consumed on any cycle where out_valid & out_ready are both high.
module tdm_demux8 (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_bit,
   input  logic       in_valid,
   input  logic       frame_start,
   output logic [0:7] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [2:0] slot,
   output logic       overrun,
   output logic       sync_err,
   output logic       o_dbg_state
);

   typedef enum logic {HUNT = 1'b0, COLLECT = 1'b1} state_t;

   state_t     r_state, w_state_n;
   logic [2:0] r_slot, w_slot_n;
   logic [0:7] r_buf, w_buf_n;
   logic [0:7] r_out_data, w_out_data_n;
   logic       r_out_valid, w_out_valid_n;
   logic       r_overrun, w_overrun_n;
   logic       r_sync_err, w_sync_err_n;
   logic       w_consume;
   logic [0:7] w_frame;

   assign w_consume = r_out_valid & out_ready;

   // Next-state logic: slot tracking, framing checks, frame hand-off.
   always_comb begin
      w_state_n     = r_state;
      w_slot_n      = r_slot;
      w_buf_n       = r_buf;
      w_out_data_n  = r_out_data;
      w_out_valid_n = r_out_valid & ~out_ready;
      w_overrun_n   = r_overrun;
      w_sync_err_n  = 1'b0;
      w_frame       = r_buf;
      w_frame[r_slot] = in_bit;
      if (in_valid) begin
         case (r_state)
            HUNT: begin
               if (frame_start) begin
                  w_buf_n    = 8'h00;
                  w_buf_n[0] = in_bit;
                  w_slot_n   = 3'd1;
                  w_state_n  = COLLECT;
               end
            end
            COLLECT: begin
               if (frame_start && (r_slot != 3'd0)) begin
                  // Marker in mid-frame: drop the partial frame, restart at slot 0.
                  w_sync_err_n = 1'b1;
                  w_buf_n      = 8'h00;
                  w_buf_n[0]   = in_bit;
                  w_slot_n     = 3'd1;
`ifdef TDM_DEMUX8_STRICT_SYNC_EN
               end else if (!frame_start && (r_slot == 3'd0)) begin
                  // Missing marker at slot 0: drop the bit and resynchronise.
                  w_sync_err_n = 1'b1;
                  w_buf_n      = 8'h00;
                  w_slot_n     = 3'd0;
                  w_state_n    = HUNT;
`endif
               end else begin
                  w_buf_n  = w_frame;
                  w_slot_n = r_slot + 3'd1;
                  if (r_slot == 3'd7) begin
                     // Frame complete: hand off if the output register is free.
                     if (!r_out_valid || w_consume) begin
                        w_out_data_n  = w_frame;
                        w_out_valid_n = 1'b1;
                     end else begin
                        w_overrun_n = 1'b1;
                     end
                     w_buf_n = 8'h00;
                  end
               end
            end
            default: w_state_n = HUNT;
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= HUNT;
         r_slot      <= 3'd0;
         r_buf       <= 8'h00;
         r_out_data  <= 8'h00;
         r_out_valid <= 1'b0;
         r_overrun   <= 1'b0;
         r_sync_err  <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_slot      <= w_slot_n;
         r_buf       <= w_buf_n;
         r_out_data  <= w_out_data_n;
         r_out_valid <= w_out_valid_n;
         r_overrun   <= w_overrun_n;
         r_sync_err  <= w_sync_err_n;
      end
   end

   assign out_data    = r_out_data;
   assign out_valid   = r_out_valid;
   assign slot        = r_slot;
   assign overrun     = r_overrun;
   assign sync_err    = r_sync_err;
   assign o_dbg_state = (r_state == COLLECT);

endmodule
